// File: rtl/scp_run_ctrl.sv
// -----------------------------------------------------------------------------
// scp_run_ctrl
//
// Run controller for a soft processor core. It holds the core in reset for a
// fixed number of clocks after reset release, then lets it run freely or
// single-step. The run ends when any of these happens:
//   - an external halt request arrives,
//   - the enabled-cycle budget is used up,
//   - the PC stops changing for a number of enabled cycles in a row.
// After the run ends, a restart request sends the core back through the reset
// hold sequence.
//
// Ports
//   clk        : rising-edge clock
//   rst        : asynchronous active-low reset
//   step_mode  : 1 = single-step, 0 = free-run
//   step_req   : step request (level, sampled every edge)
//   halt_req   : external stop request
//   restart    : rerun request, honoured only once the run has finished
//   pc_in      : current processor PC
//   core_rst   : active-high processor reset
//   core_en    : processor clock enable
//   done       : run finished (sticky until restart or reset)
//   done_cause : 00 none, 01 cycle limit, 10 PC stall, 11 halt request
//   cycle_cnt  : number of enabled cycles; saturates, never wraps
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module scp_run_ctrl #(
    parameter int unsigned RESET_CYCLES = 4,
    parameter int unsigned MAX_CYCLES   = 250,
    parameter int unsigned STALL_LIMIT  = 4,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned PC_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_mode,
    input  logic             step_req,
    input  logic             halt_req,
    input  logic             restart,
    input  logic [PC_W-1:0]  pc_in,
    output logic             core_rst,
    output logic             core_en,
    output logic             done,
    output logic [1:0]       done_cause,
    output logic [CNT_W-1:0] cycle_cnt
);

    typedef enum logic [1:0] {S_HOLD, S_RUN, S_STEP, S_DONE} state_t;

    localparam int unsigned      SW       = $clog2(STALL_LIMIT + 2);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_CYCLES);
    // The budget can only trigger if it is non-zero and fits the counter.
    localparam bit               LIMIT_ON = (MAX_CYCLES != 0) &&
                                            (64'(MAX_C) == 64'(MAX_CYCLES));
    localparam bit               STALL_ON = (STALL_LIMIT != 0);
    localparam logic [SW-1:0]    STALL_C  = SW'(STALL_LIMIT);
    localparam logic [7:0]       HOLD_C   = 8'(RESET_CYCLES);

    state_t           state_q, state_d;
    logic             core_rst_q, core_rst_d;
    logic             core_en_q, core_en_d;
    logic             done_q, done_d;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       hold_cnt_q, hold_cnt_d;
    logic [SW-1:0]    stall_cnt_q, stall_cnt_d;
    logic [PC_W-1:0]  pc_prev_q, pc_prev_d;

    logic             pc_same;
    logic [CNT_W-1:0] cnt_inc;
    logic [SW-1:0]    stall_inc;
    logic             limit_hit;
    logic             stall_hit;

    always_comb begin
        state_d     = state_q;
        core_rst_d  = core_rst_q;
        core_en_d   = core_en_q;
        done_d      = done_q;
        cause_d     = cause_q;
        cnt_d       = cnt_q;
        hold_cnt_d  = hold_cnt_q;
        stall_cnt_d = stall_cnt_q;
        pc_prev_d   = pc_prev_q;

        pc_same   = (pc_in == pc_prev_q);
        cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        stall_inc = (STALL_ON && pc_same) ? stall_cnt_q + SW'(1) : '0;
        limit_hit = LIMIT_ON && (cnt_inc == MAX_C) && (cnt_q != MAX_C);
        stall_hit = STALL_ON && pc_same && (stall_inc == STALL_C);

        case (state_q)
            S_HOLD: begin
                core_rst_d  = 1'b1;
                core_en_d   = 1'b0;
                stall_cnt_d = '0;
                pc_prev_d   = '0;
                hold_cnt_d  = hold_cnt_q + 8'd1;
                if (hold_cnt_q + 8'd1 == HOLD_C) begin
                    hold_cnt_d = '0;
                    core_rst_d = 1'b0;
                    if (step_mode) begin
                        state_d   = S_STEP;
                        core_en_d = 1'b0;
                    end else begin
                        state_d   = S_RUN;
                        core_en_d = 1'b1;
                    end
                end
            end

            S_RUN, S_STEP: begin
                if (halt_req) begin
                    // A halting edge does not count as an enabled cycle.
                    state_d   = S_DONE;
                    core_en_d = 1'b0;
                    done_d    = 1'b1;
                    cause_d   = 2'b11;
                end else begin
                    if (core_en_q) begin
                        cnt_d       = cnt_inc;
                        pc_prev_d   = pc_in;
                        stall_cnt_d = stall_inc;
                    end
                    if (core_en_q && limit_hit) begin
                        state_d   = S_DONE;
                        core_en_d = 1'b0;
                        done_d    = 1'b1;
                        cause_d   = 2'b01;
                    end else if (core_en_q && stall_hit) begin
                        state_d   = S_DONE;
                        core_en_d = 1'b0;
                        done_d    = 1'b1;
                        cause_d   = 2'b10;
                    end else if (step_mode) begin
                        // Entering step mode from RUN always starts disabled;
                        // an active step pulse masks step_req for one edge so
                        // a held request yields a pulse every second clock.
                        state_d   = S_STEP;
                        core_en_d = (state_q == S_STEP) && !core_en_q && step_req;
                    end else begin
                        state_d   = S_RUN;
                        core_en_d = 1'b1;
                    end
                end
            end

            S_DONE: begin
                if (restart) begin
                    state_d     = S_HOLD;
                    core_rst_d  = 1'b1;
                    core_en_d   = 1'b0;
                    done_d      = 1'b0;
                    cause_d     = 2'b00;
                    cnt_d       = '0;
                    hold_cnt_d  = '0;
                    stall_cnt_d = '0;
                    pc_prev_d   = '0;
                end
            end

            default: begin
                state_d = S_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_HOLD;
            core_rst_q  <= 1'b1;
            core_en_q   <= 1'b0;
            done_q      <= 1'b0;
            cause_q     <= 2'b00;
            cnt_q       <= '0;
            hold_cnt_q  <= '0;
            stall_cnt_q <= '0;
            pc_prev_q   <= '0;
        end else begin
            state_q     <= state_d;
            core_rst_q  <= core_rst_d;
            core_en_q   <= core_en_d;
            done_q      <= done_d;
            cause_q     <= cause_d;
            cnt_q       <= cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            pc_prev_q   <= pc_prev_d;
        end
    end

    assign core_rst   = core_rst_q;
    assign core_en    = core_en_q;
    assign done       = done_q;
    assign done_cause = cause_q;
    assign cycle_cnt  = cnt_q;

endmodule

// File: tb/tb_scp_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scp_run_ctrl
//
// Self-checking bench for scp_run_ctrl. A behavioural model tracks what the
// run controller must be doing from its rules. The model steps on every clock
// edge and resets on rst. A compare process checks every DUT output against
// the model on each falling edge. Directed phases add literal expectations:
//   - reset hold,
//   - cycle limit,
//   - PC stall,
//   - halt priority,
//   - single-step,
//   - asynchronous reset.
// A randomized phase follows.
// A second instance with a 4-bit unlimited counter is used to check that
// cycle_cnt saturates.
// -----------------------------------------------------------------------------
module tb_scp_run_ctrl;

    localparam int RC = 3;
    localparam int MC = 250;
    localparam int SL = 4;
    localparam int CW = 16;
    localparam int PW = 32;
    localparam int CNT_TOP = (1 << CW) - 1;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          step_mode = 1'b0;
    logic          step_req  = 1'b0;
    logic          halt_req  = 1'b0;
    logic          restart   = 1'b0;
    logic [PW-1:0] pc_in     = '0;

    logic          core_rst;
    logic          core_en;
    logic          done;
    logic [1:0]    done_cause;
    logic [CW-1:0] cycle_cnt;

    logic          zero1   = 1'b0;
    logic [7:0]    zero_pc = '0;
    logic          s_core_rst;
    logic          s_core_en;
    logic          s_done;
    logic [1:0]    s_cause;
    logic [3:0]    s_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;
    int n_runs   = 0;

    always #5 clk = ~clk;

    scp_run_ctrl #(
        .RESET_CYCLES (RC),
        .MAX_CYCLES   (MC),
        .STALL_LIMIT  (SL),
        .CNT_W        (CW),
        .PC_W         (PW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .step_mode  (step_mode),
        .step_req   (step_req),
        .halt_req   (halt_req),
        .restart    (restart),
        .pc_in      (pc_in),
        .core_rst   (core_rst),
        .core_en    (core_en),
        .done       (done),
        .done_cause (done_cause),
        .cycle_cnt  (cycle_cnt)
    );

    scp_run_ctrl #(
        .RESET_CYCLES (2),
        .MAX_CYCLES   (0),
        .STALL_LIMIT  (0),
        .CNT_W        (4),
        .PC_W         (8)
    ) u_sat (
        .clk        (clk),
        .rst        (rst),
        .step_mode  (zero1),
        .step_req   (zero1),
        .halt_req   (zero1),
        .restart    (zero1),
        .pc_in      (zero_pc),
        .core_rst   (s_core_rst),
        .core_en    (s_core_en),
        .done       (s_done),
        .done_cause (s_cause),
        .cycle_cnt  (s_cnt)
    );

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    bit            m_holding = 1'b1;   // core still in its reset hold
    int            m_hold_n  = 0;      // hold edges seen so far
    bit            m_fin     = 1'b0;   // run over
    int            m_cause   = 0;
    bit            m_single  = 1'b0;   // currently single-stepping
    bit            m_en      = 1'b0;   // core enabled for the coming edge
    int            m_cnt     = 0;
    logic [PW-1:0] m_prev    = '0;
    int            m_same    = 0;      // consecutive enabled cycles with same PC

    function automatic void m_clear();
        m_holding = 1'b1;
        m_hold_n  = 0;
        m_fin     = 1'b0;
        m_cause   = 0;
        m_single  = 1'b0;
        m_en      = 1'b0;
        m_cnt     = 0;
        m_prev    = '0;
        m_same    = 0;
    endfunction

    function automatic void m_stop(int cause);
        m_fin   = 1'b1;
        m_cause = cause;
        m_en    = 1'b0;
        n_runs++;
        $display("run %0d ended: cause=%0d cycles=%0d (t=%0t)", n_runs, cause, m_cnt, $time);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_clear();
        end else if (m_holding) begin
            m_hold_n++;
            if (m_hold_n == RC) begin
                m_holding = 1'b0;
                m_single  = step_mode;
                m_en      = !step_mode;
            end
        end else if (m_fin) begin
            if (restart) m_clear();
        end else if (halt_req) begin
            m_stop(3);
        end else begin
            bit retired;
            retired = m_en;
            if (retired) begin
                if (m_cnt < CNT_TOP) m_cnt++;
                m_same = (pc_in == m_prev) ? m_same + 1 : 0;
                m_prev = pc_in;
            end
            if (retired && MC > 0 && m_cnt == MC) begin
                m_stop(1);
            end else if (retired && SL > 0 && m_same == SL) begin
                m_stop(2);
            end else begin
                m_en     = step_mode ? (m_single && !retired && step_req) : 1'b1;
                m_single = step_mode;
            end
        end
    end

    // Single compare process: every output, every falling edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("core_rst",   core_rst,   64'(m_holding));
            chk("core_en",    core_en,    64'(m_en));
            chk("done",       done,       64'(m_fin));
            chk("done_cause", done_cause, 64'(m_cause));
            chk("cycle_cnt",  cycle_cnt,  64'(m_cnt));
        end
    end

    task automatic pulse_restart();
        @(negedge clk) restart = 1'b1;
        @(negedge clk) restart = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int n_en;
        int k;
        int i;

        #2 rst = 1'b0;
        chk_on = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_core_rst", core_rst, 1);
        chk("reset_core_en",  core_en,  0);
        chk("reset_cnt",      cycle_cnt, 0);

        // ---- reset hold, then a full run to the cycle limit ----
        pc_in = 32'h100;
        rst   = 1'b1;
        @(posedge clk) #1 chk("hold_edge1_core_rst", core_rst, 1);
        @(posedge clk) #1 chk("hold_edge2_core_rst", core_rst, 1);
        @(posedge clk) #1;
        chk("hold_edge3_core_rst", core_rst, 0);
        chk("hold_edge3_core_en",  core_en,  1);

        n_en = 0;
        i    = 0;
        while (!done && i < 400) begin
            @(negedge clk);
            if (core_en) n_en++;
            pc_in += 4;
            i++;
        end
        chk("limit_reached",  done, 1);
        chk("limit_en_count", n_en, 250);
        chk("limit_cause",    done_cause, 2'b01);
        chk("limit_cnt",      cycle_cnt, 250);
        chk("limit_core_en",  core_en, 0);
        $display("cycle-limit run: %0d enabled cycles", n_en);

        chk("sat_cnt",     s_cnt, 4'hF);
        chk("sat_core_en", s_core_en, 1);
        chk("sat_done",    s_done, 0);

        // ---- restart, then a PC stall ----
        pulse_restart();
        chk("restart_core_rst", core_rst, 1);
        chk("restart_done",     done, 0);
        chk("restart_cnt",      cycle_cnt, 0);
        chk("restart_cause",    done_cause, 0);
        k = 0;
        i = 0;
        while (!done && i < 100) begin
            @(negedge clk);
            if (core_en) begin
                k++;
                pc_in = (k >= 10) ? 32'h40 : 32'h2000 + 32'(4 * k);
            end
            i++;
        end
        chk("stall_reached", done, 1);
        chk("stall_cause",   done_cause, 2'b10);
        chk("stall_cnt",     cycle_cnt, 14);

        // ---- halt on the edge the limit would be reached ----
        pulse_restart();
        i = 0;
        while (!done && i < 400) begin
            @(negedge clk);
            pc_in += 4;
            halt_req = core_en && (cycle_cnt == 16'd249);
            i++;
        end
        halt_req = 1'b0;
        chk("halt_reached", done, 1);
        chk("halt_cause",   done_cause, 2'b11);
        chk("halt_cnt",     cycle_cnt, 249);

        // ---- single-step ----
        step_mode = 1'b1;
        pulse_restart();
        repeat (3) @(negedge clk);
        chk("step_entry_core_rst", core_rst, 0);
        chk("step_entry_core_en",  core_en, 0);
        n_en = 0;
        repeat (3) begin
            @(negedge clk);
            step_req = 1'b1;
            pc_in += 4;
            @(negedge clk);
            step_req = 1'b0;
            if (core_en) n_en++;
            pc_in += 4;
            repeat (3) begin
                @(negedge clk);
                if (core_en) n_en++;
                pc_in += 4;
            end
        end
        chk("step_pulses", n_en, 3);
        chk("step_cnt",    cycle_cnt, 3);
        $display("single-step pulses: %0d", n_en);

        n_en = 0;
        @(negedge clk) step_req = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (core_en) n_en++;
            pc_in += 4;
        end
        step_req = 1'b0;
        chk("step_held_pulses", n_en, 3);
        chk("step_held_cnt",    cycle_cnt, 6);
        $display("held step_req pulses: %0d", n_en);

        // ---- asynchronous reset in the middle of a run ----
        @(negedge clk) step_mode = 1'b0;
        repeat (5) begin
            @(negedge clk);
            pc_in += 4;
        end
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("async_core_en",  core_en, 0);
        chk("async_core_rst", core_rst, 1);
        chk("async_done",     done, 0);
        chk("async_cause",    done_cause, 0);
        chk("async_cnt",      cycle_cnt, 0);
        @(negedge clk) rst = 1'b1;

        // ---- randomized run ----
        for (int r = 0; r < 3000; r++) begin
            @(negedge clk);
            if ($urandom_range(0, 99) < 3) step_mode = ~step_mode;
            step_req = ($urandom_range(0, 2) == 0);
            halt_req = ($urandom_range(0, 149) == 0);
            restart  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 2) != 0) pc_in += 4;
            if ($urandom_range(0, 599) == 0) begin
                @(posedge clk);
                #3 rst = 1'b0;
                @(negedge clk) rst = 1'b1;
            end
        end
        @(negedge clk);
        halt_req = 1'b0;
        restart  = 1'b0;
        step_req = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
